alu_rs: RTL and testbench

Reservation station and issue scheduler for the integer ALU. Holds up to `RS_SIZE` dispatched ALU/branch micro-ops and captures missing operands from the two result broadcast buses (ALU, load/store buffer). Each cycle it issues the oldest-index ready entry to the single-cycle ALU. It sits between the dispatch stage and the ALU, and the ALU's result bus feeds back into its own wakeup port.

---
 rtl/alu_rs_pkg.sv | 52 +++++
 rtl/alu_rs_select.sv | 23 ++
 rtl/alu_rs.sv | 152 +++++++++++++++
 tb/tb_alu_rs.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared constants, entry layout and operand wakeup helper for the ALU
// reservation station.
package alu_rs_pkg;

    localparam int ROB_BIT        = 4;
    localparam int DEFAULT_RS_BIT = 3;

    localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OP_ALU_REG = 7'b0110011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;

    typedef struct packed {
        logic               has_q;
        logic [ROB_BIT-1:0] q;
        logic [31:0]        v;
    } operand_t;

    typedef struct packed {
        logic               busy;
        logic [2:0]         op;
        logic [6:0]         op_type;
        logic               op_addition;
        logic [ROB_BIT-1:0] rob;
        operand_t           opi;
        operand_t           opj;
    } rs_entry_t;

    // The ALU bus is checked first so it wins if both buses carry the same tag.
    function automatic operand_t wake_operand(
        input operand_t           o,
        input logic               alu_ready,
        input logic [31:0]        alu_res,
        input logic [ROB_BIT-1:0] alu_rob,
        input logic               lsb_ready,
        input logic [31:0]        lsb_res,
        input logic [ROB_BIT-1:0] lsb_rob
    );
        operand_t r;
        r = o;
        if (o.has_q) begin
            if (alu_ready && (o.q == alu_rob)) begin
                r.v     = alu_res;
                r.has_q = 1'b0;
            end else if (lsb_ready && (o.q == lsb_rob)) begin
                r.v     = lsb_res;
                r.has_q = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Lowest-index priority encoder: reports whether any request bit is set and
// the index of the lowest one.
module rs_select #(
    parameter int WIDTH   = 8,
    parameter int IDX_BIT = 3
) (
    input  logic [WIDTH-1:0]   req,
    output logic               found,
    output logic [IDX_BIT-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_BIT'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: captures operands from the ALU and
// load/store result buses and issues the lowest-index ready entry each cycle.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_BIT  = DEFAULT_RS_BIT,
    parameter int RS_SIZE = 1 << RS_BIT
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear_in,

    input  logic               dsp_valid,
    input  logic [2:0]         dsp_op,
    input  logic [6:0]         dsp_op_type,
    input  logic               dsp_op_addition,
    input  logic [ROB_BIT-1:0] dsp_rob_entry,
    input  logic [31:0]        dsp_vi,
    input  logic               dsp_has_qi,
    input  logic [ROB_BIT-1:0] dsp_qi,
    input  logic [31:0]        dsp_vj,
    input  logic               dsp_has_qj,
    input  logic [ROB_BIT-1:0] dsp_qj,
    output logic               full,

    input  logic               alu_cdb_ready,
    input  logic [31:0]        alu_cdb_res,
    input  logic [ROB_BIT-1:0] alu_cdb_rob,
    input  logic               lsb_cdb_ready,
    input  logic [31:0]        lsb_cdb_res,
    input  logic [ROB_BIT-1:0] lsb_cdb_rob,

    output logic               alu_valid,
    output logic [31:0]        alu_vi,
    output logic [31:0]        alu_vj,
    output logic [2:0]         alu_op,
    output logic [6:0]         alu_op_type,
    output logic               alu_op_addition,
    output logic [ROB_BIT-1:0] alu_rob_entry
);

    rs_entry_t entries      [RS_SIZE];
    rs_entry_t entries_next [RS_SIZE];

    logic [RS_SIZE-1:0] busy_vec;
    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] ready_vec;

    logic              free_found;
    logic [RS_BIT-1:0] free_idx;
    logic              issue_found;
    logic [RS_BIT-1:0] issue_idx;
    logic              dsp_accept;
    rs_entry_t         dsp_entry;
    rs_entry_t         issue_entry;

    // Ready means no pending tag as of the pre-edge state; same-cycle wakeups
    // only become issuable on the following edge.
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = entries[i].busy;
            ready_vec[i] = entries[i].busy && !entries[i].opi.has_q
                                           && !entries[i].opj.has_q;
        end
    end

    assign free_vec   = ~busy_vec;
    assign full       = &busy_vec;
    assign dsp_accept = dsp_valid && !full;

    rs_select #(.WIDTH(RS_SIZE), .IDX_BIT(RS_BIT)) u_free_select (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_select #(.WIDTH(RS_SIZE), .IDX_BIT(RS_BIT)) u_ready_select (
        .req   (ready_vec),
        .found (issue_found),
        .idx   (issue_idx)
    );

    assign issue_entry = entries[issue_idx];

    // Incoming operands are bypassed against the buses broadcasting this cycle.
    always_comb begin
        dsp_entry             = '0;
        dsp_entry.busy        = 1'b1;
        dsp_entry.op          = dsp_op;
        dsp_entry.op_type     = dsp_op_type;
        dsp_entry.op_addition = dsp_op_addition;
        dsp_entry.rob         = dsp_rob_entry;
        dsp_entry.opi = wake_operand('{has_q: dsp_has_qi, q: dsp_qi, v: dsp_vi},
                                     alu_cdb_ready, alu_cdb_res, alu_cdb_rob,
                                     lsb_cdb_ready, lsb_cdb_res, lsb_cdb_rob);
        dsp_entry.opj = wake_operand('{has_q: dsp_has_qj, q: dsp_qj, v: dsp_vj},
                                     alu_cdb_ready, alu_cdb_res, alu_cdb_rob,
                                     lsb_cdb_ready, lsb_cdb_res, lsb_cdb_rob);
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            entries_next[i] = entries[i];
            if (entries[i].busy) begin
                entries_next[i].opi = wake_operand(entries[i].opi,
                                          alu_cdb_ready, alu_cdb_res, alu_cdb_rob,
                                          lsb_cdb_ready, lsb_cdb_res, lsb_cdb_rob);
                entries_next[i].opj = wake_operand(entries[i].opj,
                                          alu_cdb_ready, alu_cdb_res, alu_cdb_rob,
                                          lsb_cdb_ready, lsb_cdb_res, lsb_cdb_rob);
            end
            if (issue_found && (issue_idx == RS_BIT'(i))) begin
                entries_next[i].busy = 1'b0;
            end
            if (dsp_accept && free_found && (free_idx == RS_BIT'(i))) begin
                entries_next[i] = dsp_entry;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || (rdy_in && clear_in)) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries[i] <= '0;
            end
            alu_valid       <= 1'b0;
            alu_vi          <= '0;
            alu_vj          <= '0;
            alu_op          <= '0;
            alu_op_type     <= '0;
            alu_op_addition <= 1'b0;
            alu_rob_entry   <= '0;
        end else if (rdy_in) begin
            entries <= entries_next;
            if (issue_found) begin
                alu_valid       <= 1'b1;
                alu_vi          <= issue_entry.opi.v;
                alu_vj          <= issue_entry.opj.v;
                alu_op          <= issue_entry.op;
                alu_op_type     <= issue_entry.op_type;
                alu_op_addition <= issue_entry.op_addition;
                alu_rob_entry   <= issue_entry.rob;
            end else begin
                alu_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: a slot-list model predicts the issue stream
// every cycle, and directed literal checks pin key points of each scenario.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic               clk_in;
    logic               rst_in;
    logic               rdy_in;
    logic               clear_in;
    logic               dsp_valid;
    logic [2:0]         dsp_op;
    logic [6:0]         dsp_op_type;
    logic               dsp_op_addition;
    logic [ROB_BIT-1:0] dsp_rob_entry;
    logic [31:0]        dsp_vi;
    logic               dsp_has_qi;
    logic [ROB_BIT-1:0] dsp_qi;
    logic [31:0]        dsp_vj;
    logic               dsp_has_qj;
    logic [ROB_BIT-1:0] dsp_qj;
    logic               full;
    logic               alu_cdb_ready;
    logic [31:0]        alu_cdb_res;
    logic [ROB_BIT-1:0] alu_cdb_rob;
    logic               lsb_cdb_ready;
    logic [31:0]        lsb_cdb_res;
    logic [ROB_BIT-1:0] lsb_cdb_rob;
    logic               alu_valid;
    logic [31:0]        alu_vi;
    logic [31:0]        alu_vj;
    logic [2:0]         alu_op;
    logic [6:0]         alu_op_type;
    logic               alu_op_addition;
    logic [ROB_BIT-1:0] alu_rob_entry;

    int n_compared;
    int n_mismatched;

    alu_rs dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .clear_in        (clear_in),
        .dsp_valid       (dsp_valid),
        .dsp_op          (dsp_op),
        .dsp_op_type     (dsp_op_type),
        .dsp_op_addition (dsp_op_addition),
        .dsp_rob_entry   (dsp_rob_entry),
        .dsp_vi          (dsp_vi),
        .dsp_has_qi      (dsp_has_qi),
        .dsp_qi          (dsp_qi),
        .dsp_vj          (dsp_vj),
        .dsp_has_qj      (dsp_has_qj),
        .dsp_qj          (dsp_qj),
        .full            (full),
        .alu_cdb_ready   (alu_cdb_ready),
        .alu_cdb_res     (alu_cdb_res),
        .alu_cdb_rob     (alu_cdb_rob),
        .lsb_cdb_ready   (lsb_cdb_ready),
        .lsb_cdb_res     (lsb_cdb_res),
        .lsb_cdb_rob     (lsb_cdb_rob),
        .alu_valid       (alu_valid),
        .alu_vi          (alu_vi),
        .alu_vj          (alu_vj),
        .alu_op          (alu_op),
        .alu_op_type     (alu_op_type),
        .alu_op_addition (alu_op_addition),
        .alu_rob_entry   (alu_rob_entry)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          busy;
        logic [2:0]  op;
        logic [6:0]  op_type;
        logic        add;
        logic [3:0]  rob;
        logic [31:0] vi;
        logic [31:0] vj;
        bit          wait_i;
        bit          wait_j;
        logic [3:0]  qi;
        logic [3:0]  qj;
    } slot_t;

    slot_t       slots [8];
    bit          model_live;
    logic        e_valid;
    logic [31:0] e_vi;
    logic [31:0] e_vj;
    logic [2:0]  e_op;
    logic [6:0]  e_op_type;
    logic        e_add;
    logic [3:0]  e_rob;
    logic        e_full;

    initial model_live = 1'b0;

    task automatic bus_lookup(input logic [3:0] tag, output bit hit, output logic [31:0] val);
        hit = 1'b0;
        val = '0;
        if (alu_cdb_ready && alu_cdb_rob == tag) begin
            hit = 1'b1;
            val = alu_cdb_res;
        end else if (lsb_cdb_ready && lsb_cdb_rob == tag) begin
            hit = 1'b1;
            val = lsb_cdb_res;
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < 8; i++) slots[i].busy = 1'b0;
        e_valid = 0; e_vi = 0; e_vj = 0; e_op = 0; e_op_type = 0; e_add = 0; e_rob = 0;
    endtask

    task automatic model_cycle();
        int          pick;
        int          hole;
        bit          hit;
        logic [31:0] val;
        pick = -1;
        hole = -1;
        for (int i = 0; i < 8; i++)
            if (pick < 0 && slots[i].busy && !slots[i].wait_i && !slots[i].wait_j) pick = i;
        for (int i = 0; i < 8; i++)
            if (hole < 0 && !slots[i].busy) hole = i;
        for (int i = 0; i < 8; i++) begin
            if (slots[i].busy && slots[i].wait_i) begin
                bus_lookup(slots[i].qi, hit, val);
                if (hit) begin slots[i].vi = val; slots[i].wait_i = 0; end
            end
            if (slots[i].busy && slots[i].wait_j) begin
                bus_lookup(slots[i].qj, hit, val);
                if (hit) begin slots[i].vj = val; slots[i].wait_j = 0; end
            end
        end
        if (pick >= 0) begin
            e_valid = 1; e_vi = slots[pick].vi; e_vj = slots[pick].vj;
            e_op = slots[pick].op; e_op_type = slots[pick].op_type;
            e_add = slots[pick].add; e_rob = slots[pick].rob;
            slots[pick].busy = 0;
        end else begin
            e_valid = 0;
        end
        if (dsp_valid && hole >= 0) begin
            slots[hole].busy = 1; slots[hole].op = dsp_op; slots[hole].op_type = dsp_op_type;
            slots[hole].add = dsp_op_addition; slots[hole].rob = dsp_rob_entry;
            slots[hole].vi = dsp_vi; slots[hole].qi = dsp_qi; slots[hole].wait_i = dsp_has_qi;
            slots[hole].vj = dsp_vj; slots[hole].qj = dsp_qj; slots[hole].wait_j = dsp_has_qj;
            if (dsp_has_qi) begin
                bus_lookup(dsp_qi, hit, val);
                if (hit) begin slots[hole].vi = val; slots[hole].wait_i = 0; end
            end
            if (dsp_has_qj) begin
                bus_lookup(dsp_qj, hit, val);
                if (hit) begin slots[hole].vj = val; slots[hole].wait_j = 0; end
            end
        end
    endtask

    always @(posedge clk_in) begin
        if (rst_in) model_flush();
        else if (rdy_in) begin
            if (clear_in) model_flush();
            else model_cycle();
        end
        e_full = 1'b1;
        for (int i = 0; i < 8; i++) if (!slots[i].busy) e_full = 1'b0;
        model_live = 1'b1;
    end

    always @(negedge clk_in) begin
        if (model_live) begin
            n_compared++;
            if ({alu_valid, alu_vi, alu_vj, alu_op, alu_op_type, alu_op_addition, alu_rob_entry, full} !==
                {e_valid, e_vi, e_vj, e_op, e_op_type, e_add, e_rob, e_full}) begin
                n_mismatched++;
                $display("[TB] FAIL model_cmp t=%0t dut v=%b vi=%h vj=%h op=%h ty=%h add=%b rob=%h full=%b model v=%b vi=%h vj=%h op=%h ty=%h add=%b rob=%h full=%b",
                         $time, alu_valid, alu_vi, alu_vj, alu_op, alu_op_type, alu_op_addition, alu_rob_entry, full,
                         e_valid, e_vi, e_vj, e_op, e_op_type, e_add, e_rob, e_full);
            end
        end
    end

    task automatic checkOutput(input string name, input logic v, input logic [31:0] vi,
                               input logic [31:0] vj, input logic [3:0] rob, input logic f);
        n_compared++;
        if ({alu_valid, alu_vi, alu_vj, alu_rob_entry, full} !== {v, vi, vj, rob, f} ||
            {e_valid, e_vi, e_vj, e_rob, e_full} !== {v, vi, vj, rob, f}) begin
            n_mismatched++;
            $display("[TB] FAIL %s dut v=%b vi=%h vj=%h rob=%h full=%b model v=%b vi=%h vj=%h rob=%h full=%b required v=%b vi=%h vj=%h rob=%h full=%b",
                     name, alu_valid, alu_vi, alu_vj, alu_rob_entry, full,
                     e_valid, e_vi, e_vj, e_rob, e_full, v, vi, vj, rob, f);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [6:0] ty, input logic add,
                                 input logic [3:0] rob, input logic [31:0] vi, input logic hqi,
                                 input logic [3:0] qi, input logic [31:0] vj, input logic hqj,
                                 input logic [3:0] qj);
        dsp_valid = 1; dsp_op = op; dsp_op_type = ty; dsp_op_addition = add; dsp_rob_entry = rob;
        dsp_vi = vi; dsp_has_qi = hqi; dsp_qi = qi; dsp_vj = vj; dsp_has_qj = hqj; dsp_qj = qj;
    endtask

    task automatic idle();
        dsp_valid = 0; dsp_op = 0; dsp_op_type = 0; dsp_op_addition = 0; dsp_rob_entry = 0;
        dsp_vi = 0; dsp_has_qi = 0; dsp_qi = 0; dsp_vj = 0; dsp_has_qj = 0; dsp_qj = 0;
        alu_cdb_ready = 0; alu_cdb_res = 0; alu_cdb_rob = 0;
        lsb_cdb_ready = 0; lsb_cdb_res = 0; lsb_cdb_rob = 0;
    endtask

    task automatic aluBus(input logic [3:0] rob, input logic [31:0] res);
        alu_cdb_ready = 1; alu_cdb_rob = rob; alu_cdb_res = res;
    endtask

    task automatic lsbBus(input logic [3:0] rob, input logic [31:0] res);
        lsb_cdb_ready = 1; lsb_cdb_rob = rob; lsb_cdb_res = res;
    endtask

    task automatic step();
        @(negedge clk_in);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_in = 1; rdy_in = 1; clear_in = 0;
        idle();
        repeat (2) step();
        rst_in = 0;
        checkOutput("reset_init", 0, 0, 0, 0, 0);

        // Reset with two waiting entries; their tags then broadcast.
        applyStimulus(0, OP_ALU_REG, 0, 5, 1, 1, 6, 2, 0, 0); step();
        applyStimulus(0, OP_ALU_REG, 0, 6, 1, 0, 0, 2, 1, 7); step();
        idle(); rst_in = 1; step();
        rst_in = 0;
        checkOutput("reset_clears", 0, 0, 0, 0, 0);
        aluBus(6, 32'hAA); lsbBus(7, 32'hBB); step();
        idle();
        checkOutput("reset_no_issue_a", 0, 0, 0, 0, 0); step();
        checkOutput("reset_no_issue_b", 0, 0, 0, 0, 0);

        // Simple ADDI with both operands present.
        applyStimulus(0, OP_ALU_IMM, 0, 3, 5, 0, 0, 7, 0, 0); step();
        idle();
        checkOutput("addi_not_yet", 0, 0, 0, 0, 0); step();
        checkOutput("addi_issue", 1, 5, 7, 3, 0); step();
        checkOutput("addi_done", 0, 5, 7, 3, 0);

        // Wakeup from the load bus.
        applyStimulus(0, OP_ALU_REG, 0, 1, 0, 1, 2, 3, 0, 0); step();
        idle(); lsbBus(2, 32'h100); step();
        idle();
        checkOutput("lsb_woken", 0, 5, 7, 3, 0); step();
        checkOutput("lsb_issue", 1, 32'h100, 3, 1, 0); step();

        // Dispatch bypass from the ALU bus.
        applyStimulus(0, OP_ALU_REG, 1, 5, 11, 0, 0, 0, 1, 4); aluBus(4, 9); step();
        idle();
        checkOutput("bypass_wait", 0, 32'h100, 3, 1, 0); step();
        checkOutput("bypass_issue", 1, 11, 9, 5, 0); step();

        // Fill all entries on tag 1, then drain in index order.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'(i), OP_ALU_REG, 0, 4'(8 + i), 0, 1, 1, 32'(2 * i), 0, 0);
            step();
        end
        idle();
        checkOutput("fill_full", 0, 11, 9, 5, 1);
        aluBus(1, 32'h55); step();
        idle();
        checkOutput("fill_woken", 0, 11, 9, 5, 1); step();
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("fill_issue%0d", i), 1, 32'h55, 32'(2 * i), 4'(8 + i), 0);
            step();
        end
        checkOutput("fill_drained", 0, 32'h55, 14, 15, 0);

        // Flush with two ready entries plus a simultaneous dispatch.
        applyStimulus(0, OP_ALU_REG, 0, 0, 1, 1, 9, 2, 0, 0); step();
        applyStimulus(0, OP_ALU_REG, 0, 1, 1, 1, 9, 2, 0, 0); step();
        applyStimulus(0, OP_ALU_REG, 0, 2, 5, 0, 0, 6, 1, 10); step();
        applyStimulus(0, OP_ALU_REG, 0, 3, 5, 0, 0, 6, 1, 10); step();
        idle(); aluBus(9, 32'h77); step();
        idle();
        checkOutput("flush_pre", 0, 32'h55, 14, 15, 0);
        clear_in = 1;
        applyStimulus(3'b001, OP_BRANCH, 0, 7, 1, 0, 0, 1, 0, 0); step();
        clear_in = 0; idle();
        checkOutput("flush_cleared", 0, 0, 0, 0, 0);
        aluBus(10, 32'h88); step();
        idle();
        checkOutput("flush_quiet_a", 0, 0, 0, 0, 0); step();
        checkOutput("flush_quiet_b", 0, 0, 0, 0, 0);

        // Three-cycle rdy_in stall in the middle of an issue stream.
        applyStimulus(0, OP_ALU_IMM, 0, 11, 1, 0, 0, 2, 0, 0); step();
        applyStimulus(0, OP_ALU_IMM, 0, 12, 3, 0, 0, 4, 0, 0); step();
        idle();
        checkOutput("stall_pre", 1, 1, 2, 11, 0);
        rdy_in = 0; step();
        checkOutput("stall_hold0", 1, 1, 2, 11, 0); step();
        checkOutput("stall_hold1", 1, 1, 2, 11, 0); step();
        checkOutput("stall_hold2", 1, 1, 2, 11, 0);
        rdy_in = 1;
        applyStimulus(0, OP_ALU_IMM, 0, 13, 5, 0, 0, 6, 0, 0); step();
        idle();
        checkOutput("stall_resume", 1, 3, 4, 12, 0); step();
        checkOutput("stall_next", 1, 5, 6, 13, 0); step();
        checkOutput("stall_done", 0, 5, 6, 13, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
